// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide engine: funct encodings, FSM states
// and decode helpers.
package muldiv_pkg;

  localparam logic [5:0]  FUNCT_MULT    = 6'b011000;
  localparam logic [5:0]  FUNCT_MULTU   = 6'b011001;
  localparam logic [5:0]  FUNCT_DIV     = 6'b011010;
  localparam logic [5:0]  FUNCT_DIVU    = 6'b011011;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic funct_valid(input logic [5:0] f);
    case (f)
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: funct_valid = 1'b1;
      default:                                        funct_valid = 1'b0;
    endcase
  endfunction

  function automatic logic funct_is_div(input logic [5:0] f);
    case (f)
      FUNCT_DIV, FUNCT_DIVU: funct_is_div = 1'b1;
      default:               funct_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic funct_is_signed(input logic [5:0] f);
    case (f)
      FUNCT_MULT, FUNCT_DIV: funct_is_signed = 1'b1;
      default:               funct_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_restoring_step.sv
// One restoring-division iteration: shift a dividend bit into the partial
// remainder and keep the trial subtraction only when it does not underflow.
module muldiv_restoring_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  assign trial_s = {rem, dividend_bit};
  assign diff_s  = trial_s - {1'b0, divisor};

  // Trial subtract: the remainder stays below the divisor, so WIDTH bits suffice
  always_comb begin
    if (trial_s >= {1'b0, divisor}) begin
      quot_bit = 1'b1;
      rem_next = diff_s[WIDTH-1:0];
    end else begin
      quot_bit = 1'b0;
      rem_next = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine delivering {HI,LO} with a one-cycle multWe strobe.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiply path; divides stay iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   busA,
  input  logic [WIDTH-1:0]   busB,
  input  logic               cancel,
  output logic               busy,
  output logic               multWe,
  output logic [2*WIDTH-1:0] busmult
);

  state_t             state_r, state_next_s;
  logic [4:0]         count_r;
  logic [2*WIDTH-1:0] acc_r, step_next_s, calc_result_s, wb_value_s, prod_neg_s;
  logic [WIDTH-1:0]   opa_r, opb_r;
  logic               is_div_r, neg_res_r, neg_rem_r;
  logic [2*WIDTH-1:0] busmult_r;
  logic               multwe_r, busy_r;

  logic               op_valid_s, op_div_s, op_signed_s, a_neg_s, b_neg_s;
  logic               accept_s, fast_s, last_step_s, pulse_s, wb_en_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mult_sum_s;
  logic [WIDTH-1:0]   rem_next_s, quot_raw_s, rem_raw_s, quot_fix_s, rem_fix_s;
  logic               quot_bit_s;

  assign op_valid_s  = funct_valid(funct);
  assign op_div_s    = funct_is_div(funct);
  assign op_signed_s = funct_is_signed(funct);
  assign a_neg_s     = op_signed_s & busA[WIDTH-1];
  assign b_neg_s     = op_signed_s & busB[WIDTH-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag_s     = a_neg_s ? (~busA + 32'd1) : busA;
  assign b_mag_s     = b_neg_s ? (~busB + 32'd1) : busB;
  assign accept_s    = (state_r == IDLE) && start && op_valid_s && !cancel;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod_s, fast_result_s;
  assign fast_s        = accept_s && !op_div_s;
  assign fast_prod_s   = {32'd0, a_mag_s} * {32'd0, b_mag_s};
  assign fast_result_s = (a_neg_s ^ b_neg_s) ? (~fast_prod_s + 64'd1) : fast_prod_s;
`else
  assign fast_s = 1'b0;
`endif

  // Multiply: {HI,LO} shift-right accumulator with the multiplier in LO
  assign mult_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});

  // Divide: {remainder, dividend/quotient} shift-left register
  muldiv_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem          (acc_r[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc_r[WIDTH-1]),
    .divisor      (opb_r),
    .rem_next     (rem_next_s),
    .quot_bit     (quot_bit_s)
  );

  assign step_next_s = is_div_r ? {rem_next_s, acc_r[WIDTH-2:0], quot_bit_s}
                                : {mult_sum_s, acc_r[WIDTH-1:1]};

  assign quot_raw_s  = step_next_s[WIDTH-1:0];
  assign rem_raw_s   = step_next_s[2*WIDTH-1:WIDTH];
  assign prod_neg_s  = ~step_next_s + 64'd1;

  // Sign fix-up applied to the value produced by the final iteration
  always_comb begin
    quot_fix_s    = quot_raw_s;
    rem_fix_s     = rem_raw_s;
    calc_result_s = step_next_s;
    if (opb_r == 32'd0) begin
      quot_fix_s = DIV0_QUOTIENT;
    end else if (neg_res_r) begin
      quot_fix_s = ~quot_raw_s + 32'd1;
    end else begin
      quot_fix_s = quot_raw_s;
    end
    if (neg_rem_r) begin
      rem_fix_s = ~rem_raw_s + 32'd1;
    end else begin
      rem_fix_s = rem_raw_s;
    end
    if (is_div_r) begin
      calc_result_s = {rem_fix_s, quot_fix_s};
    end else if (neg_res_r) begin
      calc_result_s = prod_neg_s;
    end else begin
      calc_result_s = step_next_s;
    end
  end

  // Writeback source: fast product at accept, otherwise the fixed-up iterative result
  always_comb begin
    wb_value_s = calc_result_s;
`ifdef MULDIV_FAST_MULT_EN
    if (fast_s) begin
      wb_value_s = fast_result_s;
    end else begin
      wb_value_s = calc_result_s;
    end
`endif
  end

  assign last_step_s = (state_r == CALC) && (count_r == 5'd31) && !cancel;
  assign pulse_s     = (state_r == DONE) && !cancel;
  assign wb_en_s     = last_step_s || fast_s;

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = fast_s ? DONE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cancel) begin
          state_next_s = IDLE;
        end else if (count_r == 5'd31) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 5'd0;
      acc_r     <= 64'd0;
      opa_r     <= 32'd0;
      opb_r     <= 32'd0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      busmult_r <= 64'd0;
      multwe_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        count_r   <= 5'd0;
        opa_r     <= a_mag_s;
        opb_r     <= b_mag_s;
        is_div_r  <= op_div_s;
        neg_res_r <= a_neg_s ^ b_neg_s;
        neg_rem_r <= a_neg_s;
        acc_r     <= op_div_s ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
      end else if (state_r == CALC) begin
        count_r <= count_r + 5'd1;
        acc_r   <= step_next_s;
      end
      if (wb_en_s) begin
        busmult_r <= wb_value_s;
      end
      multwe_r <= pulse_s;
      // busy spans accept through the strobe cycle; a cancel drops it at once
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (cancel || multwe_r) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy    = busy_r;
  assign multWe  = multwe_r;
  assign busmult = busmult_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, rst, start, cancel;
  logic [5:0]  funct;
  logic [31:0] busA, busB;
  logic        busy, multWe;
  logic [63:0] busmult;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  logic [63:0] last_result = 64'd0;

  typedef struct {
    logic [63:0] val;
    int          t;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV  = 6'b011010, F_DIVU  = 6'b011011;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .busA(busA), .busB(busB),
    .cancel(cancel), .busy(busy), .multWe(multWe), .busmult(busmult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int lat_of(input logic [5:0] f);
`ifdef MULDIV_FAST_MULT_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return 33;
  endfunction

  // Reference: plain arithmetic on 64-bit integers
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 64'd0;
    case (f)
      F_MULT:  r = sa * sb;
      F_MULTU: r = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_opnd();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 5)];
      1:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && multWe) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse busmult=%h required=no_pulse", busmult);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_value"}, busmult, mon_e.val);
        chk({mon_e.name, "_latency"}, 64'(ncyc), 64'(mon_e.t));
        last_result = mon_e.val;
      end
    end
    ncyc = ncyc + 1;
  end

  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv, input bit push, input string name);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct = f; busA = a; busB = b;
    @(posedge clk); #1;
    start = 1'b0; busA = $urandom; busB = $urandom;
    if (push) begin
      e.val = expv; e.t = ncyc + lat_of(f); e.name = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_done"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    exp_t e;
    int nb;
    logic [5:0] f;
    logic [31:0] a, b;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; funct = 6'd0; busA = 32'd0; busB = 32'd0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_multwe", 64'(multWe), 64'd0);
    chk("reset_busmult", busmult, 64'd0);
    rst = 1'b0;

    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, "multu_max");
    wait_done("multu_max");

    do_op(F_MULT, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, "mult_m3x7");
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    chk("mult_busy_cycles", 64'(nb), 64'(lat_of(F_MULT) + 1));
    wait_done("mult_m3x7");

    do_op(F_DIV, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, "div_m7d2");
    wait_done("div_m7d2");
    do_op(F_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1, "divu_100d7");
    wait_done("divu_100d7");
    do_op(F_DIV, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, "div_5d0");
    wait_done("div_5d0");
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, "div_ovf");
    wait_done("div_ovf");

    // Invalid funct and start-with-cancel must both be dropped
    do_op(6'b100000, 32'd3, 32'd4, 64'd0, 1'b0, "bad_funct");
    @(negedge clk);
    chk("bad_funct_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b1; funct = F_DIVU; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel_busy", 64'(busy), 64'd0);

    // Cancel mid-calculation
`ifdef MULDIV_FAST_MULT_EN
    f = F_DIVU;
`else
    f = F_MULT;
`endif
    do_op(f, 32'd1234, 32'd77, 64'd0, 1'b0, "cancelled");
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk); #1;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_busmult_held", busmult, last_result);
    repeat (40) @(negedge clk);
    chk("cancel_no_result", busmult, last_result);
    do_op(F_DIVU, 32'd1000, 32'd9, 64'h0000_0001_0000_006F, 1'b1, "after_cancel");
    wait_done("after_cancel");

    // Start held while busy is ignored; back-to-back issue in the strobe cycle
    do_op(F_DIVU, 32'd50, 32'd6, ref_model(F_DIVU, 32'd50, 32'd6), 1'b1, "b2b_first");
    start = 1'b1; funct = F_MULT; busA = 32'd9; busB = 32'd9;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1; funct = F_DIV; busA = -32'sd100; busB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    e.val = ref_model(F_DIV, -32'sd100, 32'd7); e.t = ncyc + 33; e.name = "b2b_second";
    exp_q.push_back(e);
    wait_done("b2b");

    // Reset mid-calculation with a second start held
    do_op(F_DIV, 32'd100, 32'd3, 64'd0, 1'b0, "reset_victim");
    start = 1'b1; funct = F_MULTU; busA = 32'd5; busB = 32'd5;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_multwe", 64'(multWe), 64'd0);
    chk("midrst_busmult", busmult, 64'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    last_result = 64'd0;
    repeat (40) @(negedge clk);
    chk("midrst_not_queued_busy", 64'(busy), 64'd0);
    chk("midrst_not_queued_busmult", busmult, 64'd0);
    do_op(F_MULT, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b1, "mult_6x7");
    wait_done("mult_6x7");

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      f = 6'(24 + $urandom_range(0, 3));
      a = rand_opnd();
      b = rand_opnd();
      do_op(f, a, b, ref_model(f, a, b), 1'b1, "rand");
      wait_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
